axi_mem_arbiter: RTL and testbench
==================================

# axi_mem_arbiter

Parametrised N-port to single-AXI-master bridge between the CPU pipeline's memory ports (instruction fetch, data access, and future extra ports) and the AXI interconnect. Each cycle it selects one pending port by fixed or round-robin priority and issues one single-beat read (AR/R) or write (AW/W/B) with full valid/ready handshakes. It holds the pipeline stalled until that port's transaction completes. At most one transaction is outstanding at any time.

## Interface
Parameters:
- N_PORTS, 2, number of requesting ports; port 0 is data, port 1 is instruction
- ADDR_W, 32, address width
- DATA_W, 32, data width; STRB_W = DATA_W/8
- ID_W, 4, AXI ID width; arid/awid = granted port index
- RR_EN, 0, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
- clk  in  1  clock; reset rst, synchronous, active-low
- rst  in  1  synchronous active-low reset
- req_en  in  N_PORTS  port i requests an access
- req_wen  in  N_PORTS*STRB_W  byte write enables; all-zero = read
- req_addr  in  N_PORTS*ADDR_W  access address
- req_wdata  in  N_PORTS*DATA_W  write data
- rsp_rdata  out  N_PORTS*DATA_W  registered read data per port
- stall  out  N_PORTS  port i must hold its request
- stall_all  out  1  OR of stall
- bus_err  out  1  one-cycle pulse on non-OKAY rresp/bresp
- AXI master: arid/araddr/arlen/arsize/arburst/arvalid out, arready in; rdata/rresp/rlast/rvalid in, rready out; awid/awaddr/awlen/awsize/awburst/awvalid out, awready in; wdata/wstrb/wlast/wvalid out, wready in; bresp/bvalid in, bready out

## Operation
- Constants: len = 0, size = log2(STRB_W), burst = INCR, wlast = 1.
- The FSM has the states IDLE, RD_ADDR, RD_DATA, WR, WR_RESP and DONE.
- IDLE: if any req_en is set, grant one port. In fixed mode the lowest index wins. In round-robin mode the search starts at ptr, and ptr becomes grant+1 mod N_PORTS when DONE exits. Latch grant, addr, wen and wdata.
  - If wen is nonzero, go to WR.
  - Otherwise go to RD_ADDR.
- RD_ADDR: arvalid = 1. On arready, go to RD_DATA.
- RD_DATA: rready = 1. On rvalid, latch rdata into rsp_rdata[grant] and go to DONE.
- WR: awvalid and wvalid both rise on entry. Each one drops after its own handshake. When both handshakes have completed (in any order, or in the same cycle), go to WR_RESP.
- WR_RESP: bready = 1. On bvalid, go to DONE.
- DONE: lasts one cycle, then IDLE.
- stall[i] = req_en[i] && !(state==DONE && grant==i).
- Requesters must hold their request stable while stalled. The latched copy is authoritative.
- rsp_rdata[i] holds its value until the next read completes for port i.
- bus_err pulses in the cycle DONE is entered, when resp != 0.
- The transaction still completes normally after an error; there is no retry.

## Timing
- Reset values: state = IDLE, ptr = 0, all valid/ready outputs = 0, rsp_rdata = 0, bus_err = 0. AXI address and data outputs = 0.
- Minimum read with arready and rvalid already high:
  - request seen in IDLE at cycle 0
  - arvalid at cycle 1
  - rready at cycle 2
  - DONE with stall low at cycle 3
- Minimum write: DONE at cycle 3, with WR at cycle 1 and WR_RESP at cycle 2.
- Back-to-back accesses: the next arbitration happens in the IDLE cycle that follows DONE.
- A port held high across DONE is treated as a new request.
- Valid signals never drop before their handshake (AXI rule).
- No address or data output changes while its valid is high.
- If rst goes low mid-transaction, everything returns to IDLE on the next edge. The slave must be reset together with this block.

## Structure
- Package axi_arb_pkg holds:
  - the state enum
  - AXI_BURST_INCR and AXI_RESP_OKAY
  - a size-from-strobe-width function
- Sub-module rr_arbiter (N, RR_EN) takes the request vector and ptr and returns a one-hot grant plus the grant index. It is purely combinational.
- Everything else lives in the top file.

## Test plan
- Single read: port 0 reads 0x1000, slave returns 0xDEADBEEF with zero wait → stall[0] high for cycles 0–2, rsp_rdata[0] = 0xDEADBEEF, araddr = 0x1000, arid = 0.
- Write with skew: port 0 writes 0xA5A5A5A5 with wen 0x3. wready is asserted 3 cycles after awready → wvalid holds until its handshake, wstrb = 0x3, bready is asserted only in WR_RESP, and there is exactly one DONE.
- Contention, fixed mode: ports 0 and 1 both read continuously → port 0 is served repeatedly and port 1 stays stalled. With RR_EN=1 the grants alternate 0,1,0,1.
- Slave wait states: arready is delayed 4 cycles and rvalid is delayed 5 → araddr stays stable, arvalid is never withdrawn, and stall_all stays high throughout.
- Error response: bresp = 2'b10 → bus_err pulses for 1 cycle and the port is released.
- Reset in RD_DATA: assert rst low for 1 cycle → the next cycle shows IDLE with every valid and ready low, and rsp_rdata = 0.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI memory arbiter.
//   arb_state_e    : transaction FSM states
//   AXI_BURST_INCR : AXI INCR burst encoding
//   AXI_RESP_OKAY  : AXI OKAY response encoding
//   axi_size()     : AxSIZE encoding for a given strobe width (bytes per beat)
package axi_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWr,
    StWrResp,
    StDone
  } arb_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic logic [2:0] axi_size(input int unsigned strb_w);
    return 3'($clog2(strb_w));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request arbiter.
//   req     : request vector
//   ptr     : search start index (used only when RR_EN = 1)
//   gnt     : one-hot grant, all-zero when nothing requests
//   gnt_idx : index of the granted request
// Fixed mode searches upward from index 0; round-robin mode from ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter bit          RR_EN = 1'b0,
  localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  int   start;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    start   = RR_EN ? int'(ptr) : 0;
    // k is the priority rank, i the port it maps to; unrolled to constant indices.
    for (int k = 0; k < int'(N); k++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!found && (i == ((start + k) % int'(N))) && req[i]) begin
          found   = 1'b1;
          gnt[i]  = 1'b1;
          gnt_idx = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/axi_mem_arbiter.sv
// N-port to single AXI master bridge, one single-beat transaction in flight.
//   clk, rst                    : clock, synchronous active-low reset
//   req_en/req_wen/req_addr/
//   req_wdata                   : per-port request (wen all-zero = read)
//   rsp_rdata                   : per-port registered read data
//   stall, stall_all            : port must hold its request / OR of stall
//   bus_err                     : pulse while in DONE after a non-OKAY response
//   ar*/r*/aw*/w*/b*            : AXI master channels
module axi_mem_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = 4,
  parameter bit          RR_EN   = 1'b0,
  localparam int unsigned STRB_W = DATA_W / 8,
  localparam int unsigned IW     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          req_en,
  input  logic [N_PORTS*STRB_W-1:0]   req_wen,
  input  logic [N_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [N_PORTS*DATA_W-1:0]   req_wdata,
  output logic [N_PORTS*DATA_W-1:0]   rsp_rdata,
  output logic [N_PORTS-1:0]          stall,
  output logic                        stall_all,
  output logic                        bus_err,
  output logic [ID_W-1:0]             arid,
  output logic [ADDR_W-1:0]           araddr,
  output logic [7:0]                  arlen,
  output logic [2:0]                  arsize,
  output logic [1:0]                  arburst,
  output logic                        arvalid,
  input  logic                        arready,
  input  logic [DATA_W-1:0]           rdata,
  input  logic [1:0]                  rresp,
  input  logic                        rlast,
  input  logic                        rvalid,
  output logic                        rready,
  output logic [ID_W-1:0]             awid,
  output logic [ADDR_W-1:0]           awaddr,
  output logic [7:0]                  awlen,
  output logic [2:0]                  awsize,
  output logic [1:0]                  awburst,
  output logic                        awvalid,
  input  logic                        awready,
  output logic [DATA_W-1:0]           wdata,
  output logic [STRB_W-1:0]           wstrb,
  output logic                        wlast,
  output logic                        wvalid,
  input  logic                        wready,
  input  logic [1:0]                  bresp,
  input  logic                        bvalid,
  output logic                        bready
);

  arb_state_e                state_q, state_d;
  logic [IW-1:0]             ptr_q, ptr_d, grant_q, grant_d, gnt_idx;
  logic [ADDR_W-1:0]         addr_q, addr_d, sel_addr;
  logic [STRB_W-1:0]         wen_q, wen_d, sel_wen;
  logic [DATA_W-1:0]         wdata_q, wdata_d, sel_wdata;
  logic                      aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                      bus_err_q, bus_err_d;
  logic [N_PORTS*DATA_W-1:0] rsp_q, rsp_d, rsp_next;
  logic [N_PORTS-1:0]        gnt;
  logic                      unused_rlast;

  // Single-beat transfers: rlast carries no information.
  assign unused_rlast = rlast;

  rr_arbiter #(
    .N     (N_PORTS),
    .RR_EN (RR_EN)
  ) u_rr_arbiter (
    .req     (req_en),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // One-hot mux of the granted port's request fields, plus read-data merge.
  always_comb begin
    sel_addr  = '0;
    sel_wen   = '0;
    sel_wdata = '0;
    rsp_next  = rsp_q;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      if (gnt[i]) begin
        sel_addr  = sel_addr  | req_addr[i*ADDR_W +: ADDR_W];
        sel_wen   = sel_wen   | req_wen[i*STRB_W +: STRB_W];
        sel_wdata = sel_wdata | req_wdata[i*DATA_W +: DATA_W];
      end
      if (grant_q == IW'(i)) rsp_next[i*DATA_W +: DATA_W] = rdata;
      stall[i] = req_en[i] && !((state_q == StDone) && (grant_q == IW'(i)));
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rsp_d     = rsp_q;
    bus_err_d = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|gnt) begin
          grant_d   = gnt_idx;
          addr_d    = sel_addr;
          wen_d     = sel_wen;
          wdata_d   = sel_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (|sel_wen) ? StWr : StRdAddr;
        end
      end
      StRdAddr: begin
        arvalid = 1'b1;
        if (arready) state_d = StRdData;
      end
      StRdData: begin
        rready = 1'b1;
        if (rvalid) begin
          rsp_d     = rsp_next;
          bus_err_d = (rresp != AXI_RESP_OKAY);
          state_d   = StDone;
        end
      end
      StWr: begin
        // AW and W complete independently; leave once both have handshaken.
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        if (awvalid && awready) aw_done_d = 1'b1;
        if (wvalid && wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = StWrResp;
      end
      StWrResp: begin
        bready = 1'b1;
        if (bvalid) begin
          bus_err_d = (bresp != AXI_RESP_OKAY);
          state_d   = StDone;
        end
      end
      StDone: begin
        if (RR_EN) ptr_d = (grant_q == IW'(N_PORTS - 1)) ? '0 : grant_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      grant_q   <= '0;
      addr_q    <= '0;
      wen_q     <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rsp_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rsp_q     <= rsp_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Request fields are latched in IDLE only, so they are stable while valid is high.
  assign arid      = ID_W'(grant_q);
  assign araddr    = addr_q;
  assign arlen     = 8'd0;
  assign arsize    = axi_size(STRB_W);
  assign arburst   = AXI_BURST_INCR;
  assign awid      = ID_W'(grant_q);
  assign awaddr    = addr_q;
  assign awlen     = 8'd0;
  assign awsize    = axi_size(STRB_W);
  assign awburst   = AXI_BURST_INCR;
  assign wdata     = wdata_q;
  assign wstrb     = wen_q;
  assign wlast     = 1'b1;
  assign rsp_rdata = rsp_q;
  assign bus_err   = bus_err_q;
  assign stall_all = |stall;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Bench for axi_mem_arbiter: a fixed-priority DUT and a round-robin DUT share
// stimulus and a programmable-latency slave. Slave and requesters drive 1ns after
// the rising edge; all observation happens on the falling edge.
module tb_axi_mem_arbiter;

  localparam int N = 2, AW = 32, DW = 32, SW = 4, IDW = 4;

  typedef struct {
    int          port;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wen;
    bit          err;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_en    = '0;
  logic [N*SW-1:0] req_wen   = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_wdata = '0;

  // Slave-driven inputs
  logic          arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = 2'b00, bresp = 2'b00;

  // Fixed-priority DUT outputs
  logic [N*DW-1:0] rsp_rdata;
  logic [N-1:0]    stall;
  logic            stall_all, bus_err;
  logic [IDW-1:0]  arid, awid;
  logic [AW-1:0]   araddr, awaddr;
  logic [7:0]      arlen, awlen;
  logic [2:0]      arsize, awsize;
  logic [1:0]      arburst, awburst;
  logic            arvalid, rready, awvalid, wvalid, wlast, bready;
  logic [DW-1:0]   wdata;
  logic [SW-1:0]   wstrb;

  // Round-robin DUT outputs (only grant ids and valids are observed)
  logic [IDW-1:0]  r_arid, r_awid;
  logic            r_arvalid, r_awvalid;
  logic [N*DW-1:0] rr_unused_rsp;
  logic [N-1:0]    rr_unused_stall;
  logic            rr_unused_sa, rr_unused_be, rr_unused_rr, rr_unused_wv, rr_unused_wl;
  logic            rr_unused_br;
  logic [AW-1:0]   rr_unused_ara, rr_unused_awa;
  logic [7:0]      rr_unused_arl, rr_unused_awl;
  logic [2:0]      rr_unused_ars, rr_unused_aws;
  logic [1:0]      rr_unused_arb, rr_unused_awb;
  logic [DW-1:0]   rr_unused_wd;
  logic [SW-1:0]   rr_unused_ws;

  axi_mem_arbiter #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IDW), .RR_EN(1'b0)) dut (
    .clk(clk), .rst(rst), .req_en(req_en), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_rdata(rsp_rdata), .stall(stall), .stall_all(stall_all),
    .bus_err(bus_err), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
    .rlast(1'b1), .rvalid(rvalid), .rready(rready), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  axi_mem_arbiter #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IDW), .RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .req_en(req_en), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_rdata(rr_unused_rsp), .stall(rr_unused_stall),
    .stall_all(rr_unused_sa), .bus_err(rr_unused_be), .arid(r_arid), .araddr(rr_unused_ara),
    .arlen(rr_unused_arl), .arsize(rr_unused_ars), .arburst(rr_unused_arb),
    .arvalid(r_arvalid), .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(1'b1),
    .rvalid(rvalid), .rready(rr_unused_rr), .awid(r_awid), .awaddr(rr_unused_awa),
    .awlen(rr_unused_awl), .awsize(rr_unused_aws), .awburst(rr_unused_awb),
    .awvalid(r_awvalid), .awready(awready), .wdata(rr_unused_wd), .wstrb(rr_unused_ws),
    .wlast(rr_unused_wl), .wvalid(rr_unused_wv), .wready(wready), .bresp(bresp),
    .bvalid(bvalid), .bready(rr_unused_br)
  );

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h1000) ? 32'hDEAD_BEEF : (a ^ 32'hC3C3_C3C3);
  endfunction

  // ---------------- slave model ----------------
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0;
  logic [1:0] rresp_cfg = 2'b00, bresp_cfg = 2'b00;

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0;
    end else begin
      if (arvalid) begin
        if (ar_cnt >= ar_dly) arready = 1; else begin arready = 0; ar_cnt++; end
      end else begin arready = 0; ar_cnt = 0; end
      if (rready) begin
        if (r_cnt >= r_dly) begin rvalid = 1; rdata = mem_val(araddr); rresp = rresp_cfg; end
        else begin rvalid = 0; r_cnt++; end
      end else begin rvalid = 0; r_cnt = 0; end
      if (awvalid) begin
        if (aw_cnt >= aw_dly) awready = 1; else begin awready = 0; aw_cnt++; end
      end else begin awready = 0; aw_cnt = 0; end
      if (wvalid) begin
        if (w_cnt >= w_dly) wready = 1; else begin wready = 0; w_cnt++; end
      end else begin wready = 0; w_cnt = 0; end
      bvalid = bready;
      bresp  = bready ? bresp_cfg : 2'b00;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  txn_t exp_q[$];
  int   rr_q[$];
  int   rr_ptr_m = 0;
  int   done_cnt = 0;
  logic done_next = 0, p_ar = 0, p_aw = 0, p_w = 0;
  logic [31:0] p_araddr, p_awaddr, p_wdata;
  logic [3:0]  p_wstrb;

  always @(negedge clk) begin
    txn_t t;
    if (!rst) begin
      done_next = 0; p_ar = 0; p_aw = 0; p_w = 0;
    end else begin
      // A pending valid must stay up with unchanged payload.
      if (p_ar) begin check("ar_hold", arvalid, 1); check("araddr_stable", araddr, p_araddr); end
      if (p_aw) begin check("aw_hold", awvalid, 1); check("awaddr_stable", awaddr, p_awaddr); end
      if (p_w) begin
        check("w_hold", wvalid, 1);
        check("wdata_stable", wdata, p_wdata);
        check("wstrb_stable", wstrb, p_wstrb);
      end
      if (done_next) begin
        done_next = 0;
        done_cnt++;
        if (exp_q.size() == 0) check("sb_underflow", 1, 0);
        else begin
          t = exp_q.pop_front();
          check("done_stall", stall[t.port], 0);
          check("bus_err", bus_err, t.err);
          if (!t.wr) check("rsp_rdata", rsp_rdata[t.port*32 +: 32], t.data);
        end
      end else check("bus_err_quiet", bus_err, 0);
      if (arvalid && arready) begin
        if (exp_q.size() == 0) check("ar_unexpected", 1, 0);
        else begin
          check("ar_is_read", exp_q[0].wr, 0);
          check("arid", arid, exp_q[0].port);
          check("araddr", araddr, exp_q[0].addr);
          check("ar_len_size_burst", {arlen, arsize, arburst}, {8'd0, 3'd2, 2'b01});
        end
        check("rr_arvalid", r_arvalid, 1);
        if (rr_q.size() != 0) check("rr_arid", r_arid, rr_q.pop_front());
      end
      if (awvalid && awready) begin
        if (exp_q.size() == 0) check("aw_unexpected", 1, 0);
        else begin
          check("aw_is_write", exp_q[0].wr, 1);
          check("awid", awid, exp_q[0].port);
          check("awaddr", awaddr, exp_q[0].addr);
          check("aw_len_size_burst", {awlen, awsize, awburst}, {8'd0, 3'd2, 2'b01});
        end
        check("rr_awvalid", r_awvalid, 1);
        if (rr_q.size() != 0) check("rr_awid", r_awid, rr_q.pop_front());
      end
      if (wvalid && wready && exp_q.size() != 0) begin
        check("wdata", wdata, exp_q[0].data);
        check("wstrb", wstrb, exp_q[0].wen);
        check("wlast", wlast, 1);
        check("bready_early", bready, 0);
      end
      if ((rvalid && rready) || (bvalid && bready)) done_next = 1;
      p_ar = arvalid && !arready; p_araddr = araddr;
      p_aw = awvalid && !awready; p_awaddr = awaddr;
      p_w  = wvalid && !wready;   p_wdata = wdata; p_wstrb = wstrb;
    end
  end

  // ---------------- driver ----------------
  task automatic post(input int port, input logic [31:0] addr, input logic [3:0] wen,
                      input logic [31:0] wd, input bit err);
    txn_t t;
    req_en[port] = 1'b1;
    req_addr[port*32 +: 32] = addr;
    req_wen[port*4 +: 4] = wen;
    req_wdata[port*32 +: 32] = wd;
    t.port = port; t.wr = (wen != 0); t.addr = addr; t.wen = wen; t.err = err;
    t.data = (wen != 0) ? wd : mem_val(addr);
    exp_q.push_back(t);
  endtask

  task automatic wait_done(input int port, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      if (stall[port]) begin
        cyc++;
        check("stall_all_held", stall_all, 1);
      end
    end while (stall[port] && cyc < 200);
    if (cyc >= 200) check("done_timeout", 0, 1);
  endtask

  task automatic access(input int port, input logic [31:0] addr, input logic [3:0] wen,
                        input logic [31:0] wd, input bit err, output int cyc);
    @(posedge clk); #1;
    post(port, addr, wen, wd, err);
    rr_q.push_back(port);
    rr_ptr_m = port ^ 1;
    wait_done(port, cyc);
    @(posedge clk); #1;
    req_en[port] = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valids"}, {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
    check({tag, "_addr"}, {araddr, awaddr}, 64'd0);
    check({tag, "_wdata"}, wdata, 0);
    check({tag, "_rsp"}, rsp_rdata, 0);
    check({tag, "_bus_err"}, bus_err, 0);
  endtask

  initial begin
    int cyc, d0, g;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_stall", {stall, stall_all}, 3'b0);
    @(posedge clk); #1 rst = 1'b1;

    // Single zero-wait read: stalled cycles 0..2, DONE at 3
    access(0, 32'h1000, 4'h0, 32'h0, 0, cyc);
    check("read_latency", cyc, 3);

    // Zero-wait write
    access(1, 32'h2200, 4'hF, 32'h1234_5678, 0, cyc);
    check("write_latency", cyc, 3);

    // Write with W lagging AW by three cycles
    w_dly = 3;
    d0 = done_cnt;
    access(0, 32'h1100, 4'h3, 32'hA5A5_A5A5, 0, cyc);
    check("write_skew_latency", cyc, 6);
    @(negedge clk);
    check("write_skew_one_done", done_cnt - d0, 1);

    // AW lagging W
    w_dly = 0; aw_dly = 2;
    access(1, 32'h1200, 4'hC, 32'h0BAD_F00D, 0, cyc);
    check("write_aw_lag_latency", cyc, 5);
    aw_dly = 0;

    // Slave wait states on AR and R
    ar_dly = 4; r_dly = 5;
    access(0, 32'h5000, 4'h0, 32'h0, 0, cyc);
    check("wait_state_latency", cyc, 12);
    ar_dly = 0; r_dly = 0;

    // Contention: both ports read continuously
    @(posedge clk); #1;
    post(0, 32'h2000, 4'h0, 32'h0, 0);
    post(1, 32'h3000, 4'h0, 32'h0, 0);
    void'(exp_q.pop_back());
    post(0, 32'h2000, 4'h0, 32'h0, 0);
    post(0, 32'h2000, 4'h0, 32'h0, 0);
    g = rr_ptr_m;
    rr_q.push_back(g); rr_q.push_back(g ^ 1); rr_q.push_back(g);
    for (int k = 0; k < 3; k++) begin
      wait_done(0, cyc);
      check("contend_latency", cyc, 3);
      check("contend_p1_stalled", stall[1], 1);
    end
    @(posedge clk); #1;
    req_en[0] = 1'b0;
    exp_q.push_back('{port: 1, wr: 0, addr: 32'h3000, data: mem_val(32'h3000), wen: 4'h0,
                      err: 0});
    rr_q.push_back(1);
    rr_ptr_m = 0;
    wait_done(1, cyc);
    check("contend_p1_latency", cyc, 3);
    @(posedge clk); #1;
    req_en[1] = 1'b0;

    // Error responses: port still released
    bresp_cfg = 2'b10;
    access(1, 32'h4400, 4'h1, 32'h0000_00EE, 1, cyc);
    check("bresp_err_latency", cyc, 3);
    bresp_cfg = 2'b00; rresp_cfg = 2'b10;
    access(0, 32'h4800, 4'h0, 32'h0, 1, cyc);
    check("rresp_err_latency", cyc, 3);
    rresp_cfg = 2'b00;

    // Reset while in RD_DATA
    r_dly = 10;
    @(posedge clk); #1;
    post(0, 32'h6000, 4'h0, 32'h0, 0);
    rr_q.push_back(0);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!rready && cyc < 50);
    check("reach_rd_data", rready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    req_en = '0;
    @(posedge clk); #2;
    rst = 1'b1;
    exp_q.delete(); rr_q.delete(); rr_ptr_m = 0;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    r_dly = 0;

    // Recovery after reset
    access(1, 32'h1000, 4'h0, 32'h0, 0, cyc);
    check("post_reset_latency", cyc, 3);
    check("post_reset_rsp1", rsp_rdata[63:32], 32'hDEAD_BEEF);
    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
